// File: rtl/gate_truth_table_checker_pkg.sv
// Shared definitions for the gate truth-table checker: FSM encoding, vector
// count and the standard 2-input truth tables (bit i = y for {a,b} = i).
package gate_truth_table_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NUM_VEC = 4;
  localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  function automatic logic expected_y(input logic [3:0] table_i, input logic [1:0] vec_i);
    return table_i[vec_i];
  endfunction

endpackage

// File: rtl/gate_truth_table_checker_dwell_counter.sv
// Hold-time counter for one input vector: counts edges since the vector was
// applied, flags the sample point (== SETTLE) and the last hold cycle (== DWELL-1).
module dwell_counter #(
  parameter  int DWELL  = 4,
  parameter  int SETTLE = 2,
  localparam int W      = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o,
  output logic settle_o
);

  localparam logic [W-1:0] TC_VAL     = W'(DWELL - 1);
  localparam logic [W-1:0] SETTLE_VAL = W'(SETTLE);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: non-blocking assignment so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o     = (cnt_q == TC_VAL);
  assign settle_o = (cnt_q == SETTLE_VAL);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Clocked stimulus/checker for a 2-input gate: sweeps {a,b} through 00..11,
// samples y_in once per hold and scores it against EXP_TABLE.
module gate_truth_table_checker
  import gate_truth_table_checker_pkg::*;
#(
  parameter int         DWELL     = 4,
  parameter int         SETTLE    = 2,
  parameter logic [3:0] EXP_TABLE = TT_OR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] err_vec
);

  if (DWELL < 2) begin : g_bad_dwell
    $error("gate_truth_table_checker: DWELL must be >= 2");
  end
  if (SETTLE < 0 || SETTLE >= DWELL) begin : g_bad_settle
    $error("gate_truth_table_checker: SETTLE must be in [0, DWELL)");
  end

  state_e     state_q;
  logic [1:0] vec_q;
  logic       a_q, b_q;
  logic       busy_q, done_q, pass_q;
  logic [2:0] err_cnt_q;
  logic [1:0] err_vec_q;

  logic       hold_last, at_settle;
  logic       cnt_clr, cnt_en;
  logic       mismatch;
  logic [2:0] err_cnt_d;

  // The counter idles at zero outside RUN, so the start edge leaves it at 0.
  assign cnt_en  = (state_q == ST_RUN);
  assign cnt_clr = (state_q != ST_RUN) || hold_last;

  dwell_counter #(
    .DWELL (DWELL),
    .SETTLE(SETTLE)
  ) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .tc_o    (hold_last),
    .settle_o(at_settle)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    mismatch  = 1'b0;
    err_cnt_d = err_cnt_q;
    if (state_q == ST_RUN && at_settle) begin
      mismatch = (y_in != expected_y(EXP_TABLE, vec_q));
    end
    if (mismatch) err_cnt_d = err_cnt_q + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vec_q     <= 2'b00;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= 3'd0;
      err_vec_q <= 2'b00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            state_q   <= ST_RUN;
            vec_q     <= 2'b00;
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
            err_cnt_q <= 3'd0;
            err_vec_q <= 2'b00;
          end
        end
        ST_RUN: begin
          if (mismatch) begin
            err_cnt_q <= err_cnt_d;
            if (err_cnt_q == 3'd0) err_vec_q <= vec_q;
          end
          if (hold_last) begin
            if (vec_q == LAST_VEC) begin
              // Use err_cnt_d: with SETTLE == DWELL-1 the last sample lands on this edge.
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == 3'd0);
              a_q     <= 1'b0;
              b_q     <= 1'b0;
            end else begin
              vec_q      <= vec_q + 2'd1;
              {a_q, b_q} <= vec_q + 2'd1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;
  assign err_vec = err_vec_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: four checker instances (good OR, AND against OR table,
// DWELL=2/SETTLE=1 held start, DWELL=2/SETTLE=0 boundary) sharing one clock.
module tb_gate_truth_table_checker;
  import gate_truth_table_checker_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       force_one = 1'b0;
  logic [3:0] start_v;

  logic [3:0] a_w, b_w, busy_w, done_w, pass_w, y_w;
  logic [2:0] err_cnt_w [4];
  logic [1:0] err_vec_w [4];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always_comb begin
    start_v = 4'b0000;
    if (start) start_v[sel] = 1'b1;
  end

  // Gates under test, modelled inline.
  assign y_w[0] = a_w[0] | b_w[0];
  assign y_w[1] = a_w[1] & b_w[1];
  assign y_w[2] = a_w[2] | b_w[2];
  assign y_w[3] = force_one ? 1'b1 : (a_w[3] | b_w[3]);

  gate_truth_table_checker #(.DWELL(4), .SETTLE(2), .EXP_TABLE(TT_OR)) u_or (
    .clk(clk), .rst(rst), .start(start_v[0]), .y_in(y_w[0]),
    .a_out(a_w[0]), .b_out(b_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .err_cnt(err_cnt_w[0]), .err_vec(err_vec_w[0]));

  gate_truth_table_checker #(.DWELL(4), .SETTLE(2), .EXP_TABLE(TT_OR)) u_and (
    .clk(clk), .rst(rst), .start(start_v[1]), .y_in(y_w[1]),
    .a_out(a_w[1]), .b_out(b_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .err_cnt(err_cnt_w[1]), .err_vec(err_vec_w[1]));

  gate_truth_table_checker #(.DWELL(2), .SETTLE(1), .EXP_TABLE(TT_OR)) u_hold (
    .clk(clk), .rst(rst), .start(start_v[2]), .y_in(y_w[2]),
    .a_out(a_w[2]), .b_out(b_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .pass(pass_w[2]), .err_cnt(err_cnt_w[2]), .err_vec(err_vec_w[2]));

  gate_truth_table_checker #(.DWELL(2), .SETTLE(0), .EXP_TABLE(TT_NOR)) u_bnd (
    .clk(clk), .rst(rst), .start(start_v[3]), .y_in(y_w[3]),
    .a_out(a_w[3]), .b_out(b_w[3]), .busy(busy_w[3]), .done(done_w[3]),
    .pass(pass_w[3]), .err_cnt(err_cnt_w[3]), .err_vec(err_vec_w[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Detailed sweep of the default OR instance, cycle by cycle.
  task automatic or_sweep(input int repulse_at, input int rst_at);
    int dones;
    dones = 0;
    sel   = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 24; t++) begin
      if (t == rst_at) begin
        check("or_pre_rst_ab", {a_w[0], b_w[0]}, 2'b10);
        rst = 1'b1;
        #1;
        check("or_rst_async", {busy_w[0], done_w[0], pass_w[0], a_w[0], b_w[0],
                               err_cnt_w[0], err_vec_w[0]}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (done_w[0]) dones++;
        end
        check("or_rst_no_done", dones, 0);
        return;
      end
      if (done_w[0]) dones++;
      if (t < 16)
        check("or_run", {busy_w[0], done_w[0], a_w[0], b_w[0]}, {2'b10, 2'(t / 4)});
      else if (t == 16)
        check("or_done", {busy_w[0], done_w[0], a_w[0], b_w[0], pass_w[0], err_cnt_w[0]},
              {2'b01, 2'b00, 1'b1, 3'd0});
      else
        check("or_idle", {busy_w[0], done_w[0], pass_w[0]}, 3'b001);
      start = (t == repulse_at);
      @(negedge clk);
    end
    check("or_done_count", dones, 1);
  endtask

  // Generic sweep on the selected instance: latency and final scoreboard.
  task automatic sweep(input string tag, input int exp_len, input logic [2:0] exp_cnt,
                       input logic [1:0] exp_vec, input logic exp_pass);
    int n;
    n     = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, busy_w[sel], 1'b1);
    while (!done_w[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_len"}, n, exp_len);
    check({tag, "_err_cnt"}, err_cnt_w[sel], exp_cnt);
    check({tag, "_err_vec"}, err_vec_w[sel], exp_vec);
    check({tag, "_pass"}, pass_w[sel], exp_pass);
    @(negedge clk);
    check({tag, "_after"}, {done_w[sel], busy_w[sel], pass_w[sel]}, {2'b00, exp_pass});
  endtask

  task automatic hold_period(input string tag);
    int n, busy_n;
    n      = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      busy_n += int'(busy_w[2]);
      if (n == 1) check({tag, "_idle"}, {busy_w[2], done_w[2]}, 2'b00);
      if (n == 2) check({tag, "_restart"}, busy_w[2], 1'b1);
    end while (!done_w[2] && n < 50);
    check({tag, "_period"}, n, 10);
    check({tag, "_busy_cycles"}, busy_n, 8);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    #1;
    for (int i = 0; i < 4; i++)
      check("reset_state", {busy_w[i], done_w[i], pass_w[i], a_w[i], b_w[i],
                            err_cnt_w[i], err_vec_w[i]}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    or_sweep(-1, -1);          // good OR
    repeat (2) @(negedge clk);
    or_sweep(5, -1);           // start re-pulsed during RUN is ignored
    repeat (2) @(negedge clk);
    or_sweep(-1, 9);           // reset during vector 10
    repeat (2) @(negedge clk);
    or_sweep(-1, -1);          // fresh sweep after the abort

    sel = 2'd1;
    sweep("and_vs_or", 16, 3'd2, 2'b01, 1'b0);

    sel = 2'd2;
    sweep("hold_good", 8, 3'd0, 2'b00, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    n = 0;
    while (!done_w[2] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hold_first_len", n, 9);
    hold_period("hold_p1");
    hold_period("hold_p2");
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_stopped", {busy_w[2], done_w[2]}, 2'b00);

    sel = 2'd3;
    force_one = 1'b1;
    sweep("bnd_one_vs_nor", 8, 3'd3, 2'b01, 1'b0);
    force_one = 1'b0;
    sweep("bnd_or_vs_nor", 8, 3'd4, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
